div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multicycle signed 32-bit divider that executes the DIV instruction. It sits directly downstream of the control unit and is started by the control unit's divControl output.
- Operands come from the A/B register outputs.
- Results go to the HI/LO registers: quotient to LO, remainder to HI.
- It reports completion and division-by-zero back to the control unit, which holds its DIV state until done and raises the exception path on div_zero.

Parameters:
- WIDTH, 32, operand/result width in bits; only 32 is verified.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- div_start  in  1  start pulse from control unit (divControl); sampled only in IDLE
- dividend  in  WIDTH  signed dividend (register A)
- divisor  in  WIDTH  signed divisor (register B)
- hi  out  WIDTH  remainder result
- lo  out  WIDTH  quotient result
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse, divide-by-zero exception request

Behaviour:
- Reset (reset low, any time, async): state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, div_zero=0. Internal partial remainder/quotient cleared.
- Reset mid-division aborts it and leaves no result.
- States: IDLE, RUN, FIX.
- IDLE, div_start=1, divisor==0:
  - div_zero=1 and done=1 for exactly the next cycle.
  - hi/lo keep their old values; state stays IDLE.
- IDLE, div_start=1, divisor!=0:
  - Capture sign_q = dividend[31]^divisor[31] and sign_r = dividend[31].
  - Capture |dividend| and |divisor|, using two's-complement magnitude; |0x80000000| = 0x80000000 as unsigned.
  - rem=0, count=0, busy=1, state->RUN.
- RUN: one unsigned restoring-division step per cycle.
  - Shift {rem,quot} left by 1.
  - Trial subtract divisor magnitude from rem, computed in WIDTH+1 bits. If non-negative, keep the difference and set quot LSB=1; else restore.
  - count increments each step. After the step with count==WIDTH-1, state->FIX (exactly WIDTH RUN cycles).
- FIX:
  - lo = sign_q ? -quot : quot; hi = sign_r ? -rem : rem.
  - done=1 for one cycle, busy=0, state->IDLE.
- Latency: start sampled at edge E0. RUN occupies E1..E32. hi/lo update and done rises at E33. So done is visible 33 cycles after the start edge.
- busy is high from after E0 until after E33.
- hi/lo are stable and hold their value outside FIX. They change only at the FIX edge.
- div_start while busy is ignored, with no restart and no queueing.
- div_start in the same cycle that done is high: accepted only if state is already IDLE. This allows back-to-back divisions with zero bubble after done.
- Operands are sampled only at the start edge. Later changes on dividend/divisor have no effect.
- Semantics: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap), with no exception.
- done and div_zero are never high while busy=1, except done in the FIX cycle.

Decomposition:
- Shared CPU package holds:
  - the div state encoding (IDLE/RUN/FIX, 2-bit localparams);
  - WORD_W=32;
  - the same constants for the planned mult unit, which reuses the state/handshake scheme.
- No sub-module is required. A small combinational helper, twos_abs (WIDTH in, WIDTH out magnitude plus sign bit), is natural and is shared with the multiplier.

Test Plan:
- Reset, then start with 100 / 7 -> done exactly 33 cycles after the start edge, lo=14, hi=2, busy high for the intervening cycles.
- Sign cases:
  - -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - 7 / -2 -> lo=-3, hi=1.
  - -7 / -2 -> lo=3, hi=-1.
- Start with divisor=0 and dividend=5 -> next cycle div_zero=1, done=1; hi/lo unchanged from the previous result; busy never rises.
- Overflow and extreme operands:
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
  - 0x80000000 / 1 -> lo=0x80000000, hi=0.
- Pulse div_start at cycle 10 of a running 1000/10 with different operands -> ignored; result lo=100, hi=0 at the original done time.
- Mid-run and back-to-back:
  - Drop reset mid-run (cycle 15) -> all outputs 0 immediately (async); after release a new 9/3 completes with lo=3, hi=0.
  - Back-to-back start on the done cycle -> second result is correct after 33 more cycles.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared CPU arithmetic package: word width, multicycle unit state encodings, helpers.
// Latency: n/a (types, constants and a purely combinational function).
// Backpressure: n/a.
package div_unit_pkg;

  localparam int WORD_W = 32;

  // Divider state encoding.
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

  // The multiplier reuses the same state/handshake scheme and word width.
  localparam int         MULT_W    = WORD_W;
  localparam logic [1:0] MULT_IDLE = DIV_IDLE;
  localparam logic [1:0] MULT_RUN  = DIV_RUN;
  localparam logic [1:0] MULT_FIX  = DIV_FIX;

  typedef enum logic [1:0] {
    ST_IDLE = DIV_IDLE,
    ST_RUN  = DIV_RUN,
    ST_FIX  = DIV_FIX
  } div_state_t;

  // Magnitude plus the original sign bit of a two's-complement word.
  typedef struct packed {
    logic              sign;
    logic [WORD_W-1:0] mag;
  } abs_t;

  // |x| as unsigned; the most negative value maps onto itself (0x80000000).
  function automatic abs_t twos_abs(input logic [WORD_W-1:0] x);
    abs_t r;
    r.sign = x[WORD_W-1];
    r.mag  = r.sign ? (~x + 1'b1) : x;
    return r;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multicycle signed divider (truncating quotient -> lo, dividend-signed remainder -> hi).
// Latency: done pulses 33 cycles after the start edge; divide-by-zero reports the next cycle.
// Backpressure: none; div_start is ignored while busy, no queueing.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem, quot, dvsr;
  logic             sign_q, sign_r;
  abs_t             a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, trial;
  logic             start_ok, start_zero;

  // Operand magnitudes, start qualification and one restoring-division trial step.
  always_comb begin
    a_abs      = twos_abs(dividend);
    b_abs      = twos_abs(divisor);
    start_ok   = (state == ST_IDLE) && div_start && (divisor != '0);
    start_zero = (state == ST_IDLE) && div_start && (divisor == '0);
    rem_sh     = {rem, quot[WIDTH-1]};
    trial      = rem_sh - {1'b0, dvsr};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: exactly WIDTH RUN cycles, then one FIX cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_RUN;
      ST_RUN:  if (count == LAST) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, shift/subtract steps, sign fix-up and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_zero) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end else if (start_ok) begin
            sign_q <= a_abs.sign ^ b_abs.sign;
            sign_r <= a_abs.sign;
            quot   <= a_abs.mag;
            dvsr   <= b_abs.mag;
            rem    <= '0;
            count  <= '0;
          end
        end
        ST_RUN: begin
          // Negative trial (top bit set) means restore the shifted remainder.
          rem   <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          quot  <= {quot[WIDTH-2:0], ~trial[WIDTH]};
          count <= count + 1'b1;
        end
        ST_FIX: begin
          lo   <= sign_q ? (~quot + 1'b1) : quot;
          hi   <= sign_r ? (~rem + 1'b1) : rem;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Busy covers the RUN and FIX cycles only.
  always_comb busy = (state != ST_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table of directed divisions plus corner sequences.
// Latency: checks done arrives 33 cycles after the start edge.
// Backpressure: checks ignored starts while busy and zero-bubble back-to-back starts.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .div_start(div_start),
    .dividend(dividend), .divisor(divisor),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present operands and a start request (inputs only, no clock advance).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
  endtask

  // Clock the start edge, then wait (bounded) for done. hi/lo must hold and busy stay
  // high until done. pulse_at>=0 injects a stray start with new operands at that cycle.
  task automatic wait_done(input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                           input int pulse_at, output int lat);
    int busy_low;
    int moved;
    busy_low = 0;
    moved    = 0;
    @(posedge clk); #1;
    div_start = 1'b0;
    if (pulse_at >= 0) begin
      dividend = 32'd77;
      divisor  = 32'd5;
    end
    lat = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_low++;
      if (hi !== hold_hi || lo !== hold_lo) moved++;
      if (pulse_at >= 0 && lat == pulse_at) begin
        dividend  = 32'd9;
        divisor   = 32'd3;
        div_start = 1'b1;
      end else begin
        div_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    div_start = 1'b0;
    chk("busy_low_cycles", 32'(busy_low), 32'd0);
    chk("hilo_moved_cycles", 32'(moved), 32'd0);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                        input int pulse_at, output int lat);
    @(negedge clk);
    start_op(a, b);
    wait_done(hold_hi, hold_lo, pulse_at, lat);
  endtask

  initial begin
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    int          lat;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[5]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
    vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0};
    vecs[7]  = '{32'd5,          32'd7,          32'd0,          32'd5};
    vecs[8]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF};
    vecs[10] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0};
    vecs[11] = '{32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0};
    vecs[12] = '{32'd123456789,  32'd1000,       32'd123456,     32'd789};

    // Reset state.
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    prev_hi = 32'd0;
    prev_lo = 32'd0;

    // Directed table.
    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b, prev_hi, prev_lo, -1, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].q);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].r);
      chk($sformatf("v%0d_div_zero", i), 32'(div_zero), 32'd0);
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      prev_hi = vecs[i].r;
      prev_lo = vecs[i].q;
    end

    // Divide by zero: one-cycle done+div_zero, results untouched, busy never rises.
    @(negedge clk);
    start_op(32'd5, 32'd0);
    @(posedge clk); #1;
    div_start = 1'b0;
    chk("dz_div_zero", 32'(div_zero), 32'd1);
    chk("dz_done", 32'(done), 32'd1);
    chk("dz_busy", 32'(busy), 32'd0);
    chk("dz_hi", hi, prev_hi);
    chk("dz_lo", lo, prev_lo);
    @(posedge clk); #1;
    chk("dz_div_zero_clear", 32'(div_zero), 32'd0);
    chk("dz_done_clear", 32'(done), 32'd0);
    chk("dz_busy_after", 32'(busy), 32'd0);

    // Stray start at cycle 10 and operand changes after the start edge are ignored.
    do_div(32'd1000, 32'd10, prev_hi, prev_lo, 10, lat);
    chk("ign_latency", 32'(lat), 32'd33);
    chk("ign_lo", lo, 32'd100);
    chk("ign_hi", hi, 32'd0);
    @(posedge clk); #1;
    chk("ign_no_restart", 32'(busy), 32'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd100;

    // Back-to-back: second start presented in the cycle done is high.
    do_div(32'd100, 32'd7, prev_hi, prev_lo, -1, lat);
    chk("b2b_first_lo", lo, 32'd14);
    chk("b2b_first_hi", hi, 32'd2);
    chk("b2b_first_done", 32'(done), 32'd1);
    start_op(32'hFFFF_FF9C, 32'd7);
    wait_done(32'd2, 32'd14, -1, lat);
    chk("b2b_latency", 32'(lat), 32'd33);
    chk("b2b_lo", lo, 32'hFFFF_FFF2);
    chk("b2b_hi", hi, 32'hFFFF_FFFE);

    // Asynchronous reset at cycle 15 of a running division.
    @(negedge clk);
    start_op(32'd1000, 32'd10);
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_div(32'd9, 32'd3, 32'd0, 32'd0, -1, lat);
    chk("post_rst_latency", 32'(lat), 32'd33);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
